// File: rtl/led_matrix_serializer.sv
// -----------------------------------------------------------------------------
// led_matrix_serializer
//
// Sends a one- or two-byte frame to an LED driver over a two-wire
// serial line (o_din / o_sclk). Each frame is:
//   START, then 8 x (BIT_LO, BIT_HI) per byte, LSB first,
//   then STOP_A, STOP_B, STOP_C.
// Every phase lasts CLK_DIV clock cycles. The driver latches o_din on the
// rising edge of o_sclk.
//
// Ports
//   CLK          system clock, rising edge
//   RST          asynchronous, active-high reset
//   i_valid      request strobe; accepted only while o_busy is low
//   i_pos[7:0]   address byte; 8'hFF selects a command-only frame
//   i_value[7:0] data byte (or command byte when i_pos == 8'hFF)
//   o_din        serial data line (registered)
//   o_sclk       serial clock line (registered)
//   o_busy       high while a frame is in progress (registered)
//   o_dbg_state  current FSM state, for observation only
//
// Handshake: a request is taken on a rising CLK edge where i_valid=1 and
// o_busy=0; i_pos/i_value are captured on that same edge. While o_busy=1,
// i_valid is ignored entirely (nothing is queued).
// -----------------------------------------------------------------------------
module led_matrix_serializer #(
    parameter int CLK_DIV = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       i_valid,
    input  logic [7:0] i_pos,
    input  logic [7:0] i_value,
    output logic       o_din,
    output logic       o_sclk,
    output logic       o_busy,
    output logic [2:0] o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_BIT_LO = 3'd2,
        S_BIT_HI = 3'd3,
        S_STOP_A = 3'd4,
        S_STOP_B = 3'd5,
        S_STOP_C = 3'd6
    } state_t;

    localparam logic [7:0] TICK_LAST = 8'(CLK_DIV - 1);

    state_t     state_q, state_d;
    logic [7:0] tick_q, tick_d;
    logic [2:0] bit_q, bit_d;
    logic       byte_q, byte_d;
    logic       two_q, two_d;
    logic [7:0] byte0_q, byte0_d;
    logic [7:0] byte1_q, byte1_d;
    logic       din_q, din_d;
    logic       sclk_q, sclk_d;
    logic       busy_q, busy_d;

    logic       tick_expire;
    logic [7:0] cur_byte;
    logic       cur_bit;

    assign tick_expire = (tick_q == TICK_LAST);

    // Next-state and counters
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        two_d   = two_q;
        byte0_d = byte0_q;
        byte1_d = byte1_q;

        if (state_q != S_IDLE) begin
            tick_d = tick_expire ? 8'd0 : tick_q + 8'd1;
        end

        case (state_q)
            S_IDLE: begin
                // busy_q is low exactly when in IDLE, so this is the
                // "i_valid && !o_busy" acceptance condition.
                if (i_valid) begin
                    state_d = S_START;
                    tick_d  = 8'd0;
                    bit_d   = 3'd0;
                    byte_d  = 1'b0;
                    two_d   = (i_pos != 8'hFF);
                    // Byte 0 is the address, or the command when address is FF.
                    byte0_d = (i_pos != 8'hFF) ? i_pos : i_value;
                    byte1_d = i_value;
                end
            end
            S_START: begin
                if (tick_expire) state_d = S_BIT_LO;
            end
            S_BIT_LO: begin
                if (tick_expire) state_d = S_BIT_HI;
            end
            S_BIT_HI: begin
                if (tick_expire) begin
                    if (bit_q == 3'd7) begin
                        bit_d = 3'd0;
                        if (two_q && !byte_q) begin
                            // Second byte follows immediately, no extra phases.
                            byte_d  = 1'b1;
                            state_d = S_BIT_LO;
                        end else begin
                            state_d = S_STOP_A;
                        end
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        state_d = S_BIT_LO;
                    end
                end
            end
            S_STOP_A: begin
                if (tick_expire) state_d = S_STOP_B;
            end
            S_STOP_B: begin
                if (tick_expire) state_d = S_STOP_C;
            end
            S_STOP_C: begin
                if (tick_expire) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Line levels are decoded from the *next* state so they can be
    // registered and change only on phase boundaries.
    assign cur_byte = byte_d ? byte1_d : byte0_d;
    assign cur_bit  = cur_byte[bit_d];

    always_comb begin
        din_d  = 1'b1;
        sclk_d = 1'b1;
        busy_d = (state_d != S_IDLE);
        case (state_d)
            S_IDLE:   begin din_d = 1'b1;    sclk_d = 1'b1; end
            S_START:  begin din_d = 1'b0;    sclk_d = 1'b1; end
            S_BIT_LO: begin din_d = cur_bit; sclk_d = 1'b0; end
            S_BIT_HI: begin din_d = cur_bit; sclk_d = 1'b1; end
            S_STOP_A: begin din_d = 1'b0;    sclk_d = 1'b0; end
            S_STOP_B: begin din_d = 1'b0;    sclk_d = 1'b1; end
            S_STOP_C: begin din_d = 1'b1;    sclk_d = 1'b1; end
            default:  begin din_d = 1'b1;    sclk_d = 1'b1; end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            tick_q  <= 8'd0;
            bit_q   <= 3'd0;
            byte_q  <= 1'b0;
            two_q   <= 1'b0;
            byte0_q <= 8'd0;
            byte1_q <= 8'd0;
            din_q   <= 1'b1;
            sclk_q  <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            two_q   <= two_d;
            byte0_q <= byte0_d;
            byte1_q <= byte1_d;
            din_q   <= din_d;
            sclk_q  <= sclk_d;
            busy_q  <= busy_d;
        end
    end

    assign o_din       = din_q;
    assign o_sclk      = sclk_q;
    assign o_busy      = busy_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_led_matrix_serializer.sv
// Bench for led_matrix_serializer. Instance 0 uses CLK_DIV=4, instance 1
// uses CLK_DIV=1. A per-cycle reference computes the expected line levels
// from the frame layout arithmetically (phase = cycles_since_accept / div).
module tb_led_matrix_serializer;

  localparam int DIV_A = 4;
  localparam int DIV_B = 1;

  logic       clk;
  logic       rst;
  logic       v_in [2];
  logic [7:0] p_in [2];
  logic [7:0] d_in [2];
  logic       din_o [2];
  logic       sclk_o [2];
  logic       busy_o [2];
  logic [2:0] dbg_o [2];

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  led_matrix_serializer #(.CLK_DIV(DIV_A)) dut_a (
    .CLK(clk), .RST(rst), .i_valid(v_in[0]), .i_pos(p_in[0]), .i_value(d_in[0]),
    .o_din(din_o[0]), .o_sclk(sclk_o[0]), .o_busy(busy_o[0]), .o_dbg_state(dbg_o[0])
  );

  led_matrix_serializer #(.CLK_DIV(DIV_B)) dut_b (
    .CLK(clk), .RST(rst), .i_valid(v_in[1]), .i_pos(p_in[1]), .i_value(d_in[1]),
    .o_din(din_o[1]), .o_sclk(sclk_o[1]), .o_busy(busy_o[1]), .o_dbg_state(dbg_o[1])
  );

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int div_of(input int i);
    return (i == 0) ? DIV_A : DIV_B;
  endfunction

  function automatic int nbytes(input logic [7:0] pos);
    return (pos == 8'hFF) ? 1 : 2;
  endfunction

  function automatic int frame_len(input logic [7:0] pos, input int div);
    return (4 + 16 * nbytes(pos)) * div;
  endfunction

  // {busy, sclk, din} expected k cycles after acceptance
  function automatic logic [2:0] ref_out(input logic [7:0] pos, input logic [7:0] val,
                                         input int div, input int k);
    int n;
    int ph;
    int j;
    logic [7:0] b;
    n  = nbytes(pos);
    ph = k / div;
    if (ph == 0) return 3'b110;                 // start: din low, sclk high
    if (ph <= 16 * n) begin
      j = (ph - 1) / 2;                         // frame bit index
      b = (n == 2 && j < 8) ? pos : val;
      return {1'b1, ((ph - 1) % 2) == 1, b[j % 8]};
    end
    case (ph - 16 * n)
      1:       return 3'b100;                   // stop A
      2:       return 3'b110;                   // stop B
      default: return 3'b111;                   // stop C
    endcase
  endfunction

  logic       m_act [2];
  int         m_k [2];
  logic [7:0] m_pos [2];
  logic [7:0] m_val [2];

  int          busy_cnt [2];
  int          cap_n [2];
  logic [15:0] cap [2];
  logic        prev_busy [2];
  logic        prev_sclk [2];

  // ---------------- scoreboard / monitor ----------------
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_act[i] = 1'b0;
      end else if (m_act[i]) begin
        m_k[i]++;
        if (m_k[i] >= frame_len(m_pos[i], div_of(i))) m_act[i] = 1'b0;
      end else if (v_in[i]) begin
        m_act[i] = 1'b1;
        m_k[i]   = 0;
        m_pos[i] = p_in[i];
        m_val[i] = d_in[i];
      end
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      logic [2:0] exp_l;
      logic [15:0] exp_w;
      logic [15:0] mask;
      int n;
      exp_l = m_act[i] ? ref_out(m_pos[i], m_val[i], div_of(i), m_k[i]) : 3'b011;
      check_val($sformatf("lines_dut%0d", i), {busy_o[i], sclk_o[i], din_o[i]}, exp_l);
      if (rst) begin
        busy_cnt[i] = 0; cap_n[i] = 0; cap[i] = '0;
        prev_busy[i] = 1'b0; prev_sclk[i] = 1'b1;
      end else begin
        if (busy_o[i]) busy_cnt[i]++;
        if (busy_o[i] && !prev_sclk[i] && sclk_o[i] && cap_n[i] < 16) begin
          cap[i][cap_n[i]] = din_o[i];
          cap_n[i]++;
        end
        if (prev_busy[i] && !busy_o[i]) begin
          n = nbytes(m_pos[i]);
          exp_w = (n == 2) ? {m_val[i], m_pos[i]} : {8'h00, m_val[i]};
          mask  = (n == 2) ? 16'hFFFF : 16'h00FF;
          check_val($sformatf("frame_len_dut%0d", i), busy_cnt[i], frame_len(m_pos[i], div_of(i)));
          check_val($sformatf("frame_nbits_dut%0d", i), cap_n[i] >= 8 * n, 1);
          check_val($sformatf("frame_bits_dut%0d", i), cap[i] & mask, exp_w);
          busy_cnt[i] = 0; cap_n[i] = 0; cap[i] = '0;
        end
        prev_busy[i] = busy_o[i];
        prev_sclk[i] = sclk_o[i];
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_req(input int i, input logic [7:0] pos, input logic [7:0] val);
    @(negedge clk);
    v_in[i] = 1'b1; p_in[i] = pos; d_in[i] = val;
    @(negedge clk);
    v_in[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int t;
    t = 0;
    @(negedge clk);
    while ((busy_o[i] || m_act[i]) && t < 400) begin
      @(negedge clk);
      t++;
    end
    check_val($sformatf("wait_idle_dut%0d", i), t < 400, 1);
  endtask

  task automatic wait_sclk_rises(input int i, input int n);
    int seen;
    int t;
    logic prev;
    seen = 0; t = 0; prev = sclk_o[i];
    while (seen < n && t < 400) begin
      @(posedge clk);
      #2;
      if (!prev && sclk_o[i]) seen++;
      prev = sclk_o[i];
      t++;
    end
    check_val("sclk_rise_wait", seen, n);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 2; i++) begin
      v_in[i] = 1'b0; p_in[i] = 8'h00; d_in[i] = 8'h00;
      m_act[i] = 1'b0; m_k[i] = 0; m_pos[i] = 8'h00; m_val[i] = 8'h00;
      busy_cnt[i] = 0; cap_n[i] = 0; cap[i] = '0;
      prev_busy[i] = 1'b0; prev_sclk[i] = 1'b1;
    end
    rst = 1'b1;
    #1;
    // reset acts before any clock edge
    check_val("reset_a", {busy_o[0], sclk_o[0], din_o[0]}, 3'b011);
    check_val("reset_b", {busy_o[1], sclk_o[1], din_o[1]}, 3'b011);
    check_val("reset_state_a", dbg_o[0], 3'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // command frame, then address+data frame
    send_req(0, 8'hFF, 8'h89);
    wait_idle(0);
    send_req(0, 8'hC3, 8'hA5);
    wait_idle(0);

    // i_valid held through a frame with changing data; only the first
    // idle-cycle values start the following frame
    @(negedge clk);
    v_in[0] = 1'b1; p_in[0] = 8'h5A; d_in[0] = 8'h3C;
    repeat (160) begin
      @(negedge clk);
      p_in[0] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      d_in[0] = 8'($urandom);
    end
    v_in[0] = 1'b0;
    wait_idle(0);

    // reset in the middle of a frame
    send_req(0, 8'hFF, 8'h89);
    wait_sclk_rises(0, 5);
    #1;
    rst = 1'b1;
    #1;
    check_val("abort_lines", {busy_o[0], sclk_o[0], din_o[0]}, 3'b011);
    check_val("abort_state", dbg_o[0], 3'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    send_req(0, 8'hFF, 8'h89);
    wait_idle(0);

    // CLK_DIV=1 instance: command and data frames
    send_req(1, 8'hFF, 8'h89);
    wait_idle(1);
    send_req(1, 8'hC3, 8'hA5);
    wait_idle(1);

    // random traffic on both, including requests while busy
    repeat (1500) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        v_in[i] = ($urandom_range(0, 9) == 0);
        p_in[i] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
        d_in[i] = 8'($urandom);
      end
    end
    v_in[0] = 1'b0;
    v_in[1] = 1'b0;
    wait_idle(0);
    wait_idle(1);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
